// File: rtl/pkg_player.sv
// Shared types and constants for the note playback sequencer and its neighbours.
// Word layout is {note, dur}; duration sits at the bottom of the ROM word.
package pkg_player;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    BUSCA  = 3'd1,
    LE     = 3'd2,
    TOCA   = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam int unsigned DUR_LSB       = 0;
  localparam int unsigned NOTE_SILENCIO = 0;

  function automatic int unsigned note_lsb(input int unsigned dur_w);
    return DUR_LSB + dur_w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/asm_leitor_notas_if.sv
// Note ROM read bus: registered address out of the player, word back one cycle later.
interface asm_leitor_notas_if #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned DUR_W  = 4
);

  logic [IDX_W+1:0]        mem_addr;
  logic [NOTE_W+DUR_W-1:0] mem_data;

  modport master (output mem_addr, input mem_data);
  modport slave  (input mem_addr, output mem_data);

endinterface

// File: rtl/divisor_tempo.sv
// Note duration counter: counts timebase ticks into units and units down to the end of a note.
module divisor_tempo
  import pkg_player::*;
#(
  parameter int unsigned DUR_W          = 4,
  parameter int unsigned TICKS_PER_UNIT = 125
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [DUR_W-1:0] i_dur,
  input  logic             i_en,
  input  logic             i_pause,
  input  logic             i_tick,
  output logic             o_done
);

  localparam int unsigned       TICK_W    = cnt_width(TICKS_PER_UNIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);

  logic [DUR_W-1:0]  r_dur_cnt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_avanca;
  logic              w_fim_unid;

  assign w_avanca   = i_en & ~i_pause & i_tick;
  assign w_fim_unid = w_avanca && (r_tick_cnt == TICK_LAST);
  // Last unit of the note ends this cycle; dur_cnt reaches zero only here, so it never wraps.
  assign o_done     = w_fim_unid && (r_dur_cnt == DUR_W'(1));

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_dur_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (i_load) begin
      r_dur_cnt  <= i_dur;
      r_tick_cnt <= '0;
    end else if (w_fim_unid) begin
      r_dur_cnt  <= r_dur_cnt - DUR_W'(1);
      r_tick_cnt <= '0;
    end else if (w_avanca) begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/asm_leitor_notas.sv
// Playback sequencer: walks the selected song in the note ROM, holding each note for its
// encoded duration and pulsing fim at the end-of-song marker or after the last word.
module asm_leitor_notas
  import pkg_player::*;
#(
  parameter int unsigned IDX_W          = 6,
  parameter int unsigned NOTE_W         = 4,
  parameter int unsigned DUR_W          = 4,
  parameter int unsigned TICKS_PER_UNIT = 125
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          select,
  input  logic                pause,
  input  logic                tick,
  asm_leitor_notas_if.master  rom,
  output logic [NOTE_W-1:0]   nota,
  output logic                tocando,
  output logic                fim
);

  localparam int unsigned      NOTE_LSB = note_lsb(DUR_W);
  localparam int unsigned      ADDR_W   = IDX_W + 2;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [NOTE_W-1:0] SILENCIO = NOTE_W'(NOTE_SILENCIO);

  estado_t           r_estado, w_estado_prox;
  logic [1:0]        r_sel, w_sel_prox;
  logic [IDX_W-1:0]  r_indice, w_indice_prox;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_prox;
  logic [NOTE_W-1:0] r_nota, w_nota_prox;
  logic [NOTE_W-1:0] w_note_rd;
  logic [DUR_W-1:0]  w_dur_rd;
  logic              w_load;
  logic              w_clear;
  logic              w_done;

  assign w_note_rd = rom.mem_data[NOTE_LSB +: NOTE_W];
  assign w_dur_rd  = rom.mem_data[DUR_LSB +: DUR_W];

  divisor_tempo #(
    .DUR_W          (DUR_W),
    .TICKS_PER_UNIT (TICKS_PER_UNIT)
  ) u_divisor (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_dur   (w_dur_rd),
    .i_en    (r_estado == TOCA),
    .i_pause (pause),
    .i_tick  (tick),
    .o_done  (w_done)
  );

  always_comb begin
    w_estado_prox   = r_estado;
    w_sel_prox      = r_sel;
    w_indice_prox   = r_indice;
    w_mem_addr_prox = r_mem_addr;
    w_nota_prox     = r_nota;
    w_load          = 1'b0;
    w_clear         = 1'b0;
    // start restarts from any state, including FIM, and outranks pause, tick and note end.
    if (start) begin
      w_estado_prox   = BUSCA;
      w_sel_prox      = select;
      w_indice_prox   = '0;
      w_mem_addr_prox = {select, {IDX_W{1'b0}}};
      w_nota_prox     = SILENCIO;
      w_clear         = 1'b1;
    end else begin
      unique case (r_estado)
        OCIOSO: w_estado_prox = OCIOSO;
        BUSCA:  w_estado_prox = LE;
        LE: begin
          if (w_dur_rd == '0) begin
            w_estado_prox = FIM;
            w_nota_prox   = SILENCIO;
          end else begin
            w_estado_prox = TOCA;
            w_nota_prox   = w_note_rd;
            w_load        = 1'b1;
          end
        end
        TOCA: begin
          if (w_done) begin
            if (r_indice == IDX_LAST) begin
              // Song space exhausted: stop here rather than wrap into the next song.
              w_estado_prox = FIM;
              w_nota_prox   = SILENCIO;
            end else begin
              w_estado_prox   = BUSCA;
              w_indice_prox   = r_indice + 1'b1;
              w_mem_addr_prox = {r_sel, w_indice_prox};
            end
          end
        end
        FIM:     w_estado_prox = OCIOSO;
        default: w_estado_prox = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_sel      <= '0;
      r_indice   <= '0;
      r_mem_addr <= '0;
      r_nota     <= SILENCIO;
    end else begin
      r_estado   <= w_estado_prox;
      r_sel      <= w_sel_prox;
      r_indice   <= w_indice_prox;
      r_mem_addr <= w_mem_addr_prox;
      r_nota     <= w_nota_prox;
    end
  end

  assign rom.mem_addr = r_mem_addr;
  // The held note stays visible through the fetch gap; only an active pause silences it.
  assign nota    = (r_estado == TOCA && pause) ? SILENCIO : r_nota;
  assign tocando = (r_estado == TOCA) && !pause;
  assign fim     = (r_estado == FIM);

endmodule

// File: tb/tb_asm_leitor_notas.sv
// Bench for asm_leitor_notas: directed and random songs compared cycle by cycle against a
// song-walking reference model built from per-cycle stimulus tables.
module tb_asm_leitor_notas;

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned NOTE_W = 4;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned TPU    = 2;
  localparam int          MaxCyc = 600;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        select;
  logic              pause;
  logic              tick;
  logic [NOTE_W-1:0] nota;
  logic              tocando;
  logic              fim;

  asm_leitor_notas_if #(.IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) rom_if ();

  asm_leitor_notas #(
    .IDX_W          (IDX_W),
    .NOTE_W         (NOTE_W),
    .DUR_W          (DUR_W),
    .TICKS_PER_UNIT (TPU)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .select  (select),
    .pause   (pause),
    .tick    (tick),
    .rom     (rom_if),
    .nota    (nota),
    .tocando (tocando),
    .fim     (fim)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_mem [256];
  always @(posedge clk) rom_if.mem_data <= rom_mem[rom_if.mem_addr];

  // Per-cycle stimulus and expected outputs.
  int         n_cyc;
  bit         st_rst   [MaxCyc];
  bit         st_start [MaxCyc];
  bit         st_pause [MaxCyc];
  bit         st_tick  [MaxCyc];
  logic [1:0] st_sel   [MaxCyc];
  int         ex_addr  [MaxCyc];
  int         ex_nota  [MaxCyc];
  int         ex_toc   [MaxCyc];
  int         ex_fim   [MaxCyc];

  int n_err = 0;
  int n_chk = 0;
  int cur_cyc;
  string scen;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s/%s cyc=%0d got=0x%0h expected=0x%0h", scen, tag, cur_cyc, got, exp);
    end
  endtask

  task automatic put(input int t, input int a, input int n, input int tc, input int f);
    if (t < n_cyc) begin
      ex_addr[t] = a;
      ex_nota[t] = n;
      ex_toc[t]  = tc;
      ex_fim[t]  = f;
    end
  endtask

  task automatic fill_idle(input int from, input int addr);
    for (int t = from; t < n_cyc; t++) put(t, addr, 0, 0, 0);
  endtask

  // Song walk started by a start pulse sampled at the end of cycle c.
  task automatic model_play(input int c, input int sel);
    int t, idx, prev, addr, n, d, rem;
    t    = c + 1;
    idx  = 0;
    prev = 0;
    while (t < n_cyc) begin
      addr = sel * 64 + idx;
      put(t, addr, prev, 0, 0);
      put(t + 1, addr, prev, 0, 0);
      t += 2;
      n = int'(rom_mem[addr]) / 16;
      d = int'(rom_mem[addr]) % 16;
      if (d == 0) begin
        put(t, addr, 0, 0, 1);
        fill_idle(t + 1, addr);
        return;
      end
      rem = d * TPU;
      while (rem > 0 && t < n_cyc) begin
        put(t, addr, st_pause[t] ? 0 : n, st_pause[t] ? 0 : 1, 0);
        if (!st_pause[t] && st_tick[t]) rem--;
        t++;
      end
      prev = n;
      if (idx == 63) begin
        put(t, addr, 0, 0, 1);
        fill_idle(t + 1, addr);
        return;
      end
      idx++;
    end
  endtask

  task automatic build_model();
    fill_idle(0, 0);
    for (int c = 0; c < n_cyc; c++) begin
      if (st_rst[c]) fill_idle(c + 1, 0);
      else if (st_start[c]) model_play(c, int'(st_sel[c]));
    end
  endtask

  task automatic clear_stim(input int n, input bit all_ticks);
    n_cyc = n;
    for (int c = 0; c < MaxCyc; c++) begin
      st_rst[c]   = 1'b0;
      st_start[c] = 1'b0;
      st_pause[c] = 1'b0;
      st_tick[c]  = all_ticks ? 1'b1 : 1'($urandom_range(0, 1));
      st_sel[c]   = 2'($urandom);
    end
  endtask

  task automatic run_scenario(input string name);
    scen = name;
    build_model();
    reset  = 1'b1;
    start  = 1'b0;
    pause  = 1'b0;
    tick   = 1'b0;
    select = 2'($urandom);
    cur_cyc = -1;
    @(posedge clk);
    #1;
    check_eq("rst_addr", int'(rom_if.mem_addr), 0);
    check_eq("rst_nota", int'(nota), 0);
    check_eq("rst_toc", int'(tocando), 0);
    check_eq("rst_fim", int'(fim), 0);
    for (int c = 0; c < n_cyc; c++) begin
      cur_cyc = c;
      reset   = st_rst[c];
      start   = st_start[c];
      select  = st_sel[c];
      pause   = st_pause[c];
      tick    = st_tick[c];
      @(negedge clk);
      check_eq("addr", int'(rom_if.mem_addr), ex_addr[c]);
      check_eq("nota", int'(nota), ex_nota[c]);
      check_eq("toc", int'(tocando), ex_toc[c]);
      check_eq("fim", int'(fim), ex_fim[c]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_song1();
    rom_mem[64] = 8'h52;
    rom_mem[65] = 8'h31;
    rom_mem[66] = 8'hA0;
  endtask

  initial begin
    int fc, ab, rs, len;
    for (int a = 0; a < 256; a++) rom_mem[a] = 8'h00;

    // Idle after reset: nothing moves without start.
    clear_stim(20, 1'b0);
    run_scenario("idle");

    load_song1();
    clear_stim(30, 1'b1);
    st_start[0] = 1'b1;
    st_sel[0]   = 2'd1;
    run_scenario("song1");

    // Pause after the first tick of note 5.
    clear_stim(35, 1'b1);
    st_start[0] = 1'b1;
    st_sel[0]   = 2'd1;
    for (int c = 4; c < 9; c++) st_pause[c] = 1'b1;
    run_scenario("pause");

    // Abort in the middle of note 3 into song 2.
    rom_mem[128] = 8'h71;
    rom_mem[129] = 8'h92;
    rom_mem[130] = 8'h00;
    clear_stim(40, 1'b1);
    st_start[0] = 1'b1;
    st_sel[0]   = 2'd1;
    st_start[9] = 1'b1;
    st_sel[9]   = 2'd2;
    run_scenario("abort");

    // Full-length song: must stop at 0xFF with no wrap.
    for (int i = 0; i < 64; i++) rom_mem[192 + i] = {4'($urandom_range(1, 15)), 4'h1};
    clear_stim(290, 1'b1);
    st_start[0] = 1'b1;
    st_sel[0]   = 2'd3;
    run_scenario("full64");

    // start coinciding with FIM.
    rom_mem[0] = 8'h43;
    rom_mem[1] = 8'h00;
    clear_stim(40, 1'b1);
    st_start[0] = 1'b1;
    st_sel[0]   = 2'd1;
    build_model();
    fc = -1;
    for (int c = 0; c < n_cyc; c++) if (fc < 0 && ex_fim[c] == 1) fc = c;
    if (fc > 0) begin
      st_start[fc] = 1'b1;
      st_sel[fc]   = 2'd0;
    end
    run_scenario("start_at_fim");

    // Reset mid-song, then replay.
    clear_stim(40, 1'b1);
    st_start[0]  = 1'b1;
    st_sel[0]    = 2'd1;
    st_rst[5]    = 1'b1;
    st_start[12] = 1'b1;
    st_sel[12]   = 2'd1;
    run_scenario("mid_reset");

    for (int it = 0; it < 8; it++) begin
      for (int s = 0; s < 4; s++) begin
        len = $urandom_range(1, 5);
        for (int i = 0; i < 64; i++) begin
          if (i < len) rom_mem[s * 64 + i] = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 4))};
          else rom_mem[s * 64 + i] = {4'($urandom_range(0, 15)), 4'h0};
        end
      end
      clear_stim(400, 1'b0);
      for (int c = 0; c < n_cyc; c++) st_pause[c] = ($urandom_range(0, 5) == 0);
      st_start[0] = 1'b1;
      ab = -1;
      if ($urandom_range(0, 1) == 1) begin
        ab = $urandom_range(5, 150);
        st_start[ab] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        rs = $urandom_range(5, 200);
        if (rs != ab) st_rst[rs] = 1'b1;
      end
      run_scenario($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
